// File: rtl/fetch_ctrl_if.sv
// Fetch-control bundle: redirect/stall requests in,
// PC-register control and IF/ID flush lines out.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              trap_req;
  logic [ADDR_W-1:0] trap_addr;
  logic              br_req;
  logic [ADDR_W-1:0] br_addr;
  logic              jmp_req;
  logic [ADDR_W-1:0] jmp_addr;
  logic              hazard_stall;
  logic              imem_ready;
  logic              halt_req;
  logic              resume;
  logic              pc_br;
  logic [ADDR_W-1:0] pc_br_addr;
  logic              pc_stall;
  logic              flush_if;
  logic              flush_id;
  logic              halted;
  logic [1:0]        redirect_src;
  logic [15:0]       redirect_cnt;

  modport slave (
    input  trap_req, trap_addr,
    input  br_req, br_addr,
    input  jmp_req, jmp_addr,
    input  hazard_stall, imem_ready,
    input  halt_req, resume,
    output pc_br, pc_br_addr, pc_stall,
    output flush_if, flush_id,
    output halted, redirect_src, redirect_cnt
  );

  modport master (
    output trap_req, trap_addr,
    output br_req, br_addr,
    output jmp_req, jmp_addr,
    output hazard_stall, imem_ready,
    output halt_req, resume,
    input  pc_br, pc_br_addr, pc_stall,
    input  flush_if, flush_id,
    input  halted, redirect_src, redirect_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: redirect arbitration,
// stall/halt control and wrong-path flush window.
module fetch_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int ADDR_W       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_FLUSH,
    S_HALT
  } state_t;

  localparam logic [3:0] FC_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t            r_state;
  state_t            w_nxt;
  logic [ADDR_W-1:0] r_paddr;
  logic [ADDR_W-1:0] w_paddr;
  logic [1:0]        r_psrc;
  logic [1:0]        w_psrc;
  logic [3:0]        r_fcnt;
  logic [3:0]        w_fcnt;
  logic              r_halted;
  logic [1:0]        r_src;
  logic [15:0]       r_cnt;

  logic [1:0]        w_wsrc;
  logic [ADDR_W-1:0] w_waddr;
  logic              w_issue;
  logic [1:0]        w_isrc;
  logic [ADDR_W-1:0] w_iaddr;
  logic              w_stall;
  logic              w_fif;

  // Pick the winning request; jmp is wrong-path in FLUSH, only trap in HALT
  always_comb begin
    w_wsrc  = 2'd0;
    w_waddr = '0;
    if (bus.trap_req) begin
      w_wsrc  = 2'd3;
      w_waddr = bus.trap_addr;
    end else if (bus.br_req && r_state != S_HALT) begin
      w_wsrc  = 2'd2;
      w_waddr = bus.br_addr;
    end else if (bus.jmp_req &&
                 (r_state == S_RUN || r_state == S_WAIT)) begin
      w_wsrc  = 2'd1;
      w_waddr = bus.jmp_addr;
    end
  end

  // Next state, pending entry, flush counter and Mealy outputs
  always_comb begin
    w_nxt   = r_state;
    w_paddr = r_paddr;
    w_psrc  = r_psrc;
    w_fcnt  = r_fcnt;
    w_issue = 1'b0;
    w_isrc  = w_wsrc;
    w_iaddr = w_waddr;
    w_stall = bus.hazard_stall | ~bus.imem_ready;
    w_fif   = 1'b0;
    unique case (1'b1)
      (r_state == S_RUN): begin
        if (w_wsrc != 2'd0) begin
          if (bus.imem_ready) begin
            w_issue = 1'b1;
          end else begin
            w_nxt   = S_WAIT;
            w_paddr = w_waddr;
            w_psrc  = w_wsrc;
          end
        end else if (bus.halt_req) begin
          w_nxt = S_HALT;
        end
      end
      (r_state == S_WAIT): begin
        w_stall = 1'b1;
        if (w_wsrc != 2'd0 && w_wsrc >= r_psrc) begin
          w_paddr = w_waddr;
          w_psrc  = w_wsrc;
        end
        w_isrc  = w_psrc;
        w_iaddr = w_paddr;
        w_issue = bus.imem_ready;
      end
      (r_state == S_FLUSH): begin
        w_fif = 1'b1;
        if (w_wsrc != 2'd0) begin
          if (bus.imem_ready) begin
            w_issue = 1'b1;
          end else begin
            w_nxt   = S_WAIT;
            w_paddr = w_waddr;
            w_psrc  = w_wsrc;
          end
        end else if (r_fcnt == 4'd0) begin
          w_nxt = S_RUN;
        end else begin
          w_fcnt = r_fcnt - 4'd1;
        end
      end
      (r_state == S_HALT): begin
        w_stall = 1'b1;
        if (w_wsrc != 2'd0) begin
          if (bus.imem_ready) begin
            w_issue = 1'b1;
          end else begin
            w_nxt   = S_WAIT;
            w_paddr = w_waddr;
            w_psrc  = w_wsrc;
          end
        end else if (bus.resume) begin
          w_nxt = S_RUN;
        end
      end
      default: w_nxt = S_RUN;
    endcase
    if (!rst_n) begin
      w_issue = 1'b0;
      w_fif   = 1'b0;
    end
    if (w_issue) begin
      w_nxt   = S_FLUSH;
      w_fcnt  = FC_LOAD;
      w_stall = 1'b0;
      w_fif   = 1'b1;
      w_paddr = '0;
      w_psrc  = 2'd0;
    end
  end

  // State register with pending entry and flush counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_paddr <= '0;
      r_psrc  <= 2'd0;
      r_fcnt  <= 4'd0;
    end else begin
      r_state <= w_nxt;
      r_paddr <= w_paddr;
      r_psrc  <= w_psrc;
      r_fcnt  <= w_fcnt;
    end
  end

  // Registered status: halt flag, last source, saturating redirect count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
      r_src    <= 2'd0;
      r_cnt    <= 16'd0;
    end else begin
      r_halted <= (w_nxt == S_HALT);
      if (w_issue) begin
        r_src <= w_isrc;
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign bus.pc_br        = w_issue;
  assign bus.pc_br_addr   = w_issue ? w_iaddr : '0;
  assign bus.pc_stall     = w_stall;
  assign bus.flush_if     = w_fif;
  assign bus.flush_id     = w_issue & w_isrc[1];
  assign bus.halted       = r_halted;
  assign bus.redirect_src = r_src;
  assign bus.redirect_cnt = r_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a cycle-level
// reference model compared on every falling edge.
module tb_fetch_ctrl;

  localparam int FC = 2;
  localparam int M_RUN = 0;
  localparam int M_WAIT = 1;
  localparam int M_FLUSH = 2;
  localparam int M_HALT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  fetch_ctrl_if #(.ADDR_W(32)) b ();

  fetch_ctrl #(
    .FLUSH_CYCLES(FC),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b)
  );

  always #5 clk = ~clk;

  int          m_mode;
  logic [31:0] m_paddr;
  int          m_psrc;
  int          m_left;
  bit          m_halted;
  int          m_src;
  int          m_cnt;
  bit          x_br;
  bit          x_stall;
  bit          x_fif;
  bit          x_fid;
  logic [31:0] x_addr;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h",
               nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN;
    m_paddr = 0;
    m_psrc = 0;
    m_left = 0;
    m_halted = 0;
    m_src = 0;
    m_cnt = 0;
  endtask

  // One cycle of the rules: outputs from current inputs, state on commit
  task automatic model_eval(input bit commit);
    int          req;
    int          src;
    logic [31:0] raddr;
    logic [31:0] addr;
    bit          go;
    req = 0;
    raddr = 0;
    if (b.trap_req) begin
      req = 3; raddr = b.trap_addr;
    end else if (b.br_req && m_mode != M_HALT) begin
      req = 2; raddr = b.br_addr;
    end else if (b.jmp_req &&
                 (m_mode == M_RUN || m_mode == M_WAIT)) begin
      req = 1; raddr = b.jmp_addr;
    end
    src = req;
    addr = raddr;
    if (m_mode == M_WAIT && req < m_psrc) begin
      src = m_psrc; addr = m_paddr;
    end
    go = (src != 0) && b.imem_ready && rst_n;
    x_br = go;
    x_addr = go ? addr : 32'h0;
    x_fid = go && src >= 2;
    x_fif = go || (m_mode == M_FLUSH);
    if (go) x_stall = 0;
    else if (m_mode == M_WAIT || m_mode == M_HALT) x_stall = 1;
    else x_stall = b.hazard_stall || !b.imem_ready;
    if (commit) begin
      if (go) begin
        m_mode = M_FLUSH;
        m_left = FC;
        m_src = src;
        if (m_cnt < 65535) m_cnt++;
        m_psrc = 0;
        m_paddr = 0;
      end else if (src != 0) begin
        m_mode = M_WAIT;
        m_psrc = src;
        m_paddr = addr;
      end else if (m_mode == M_RUN) begin
        if (b.halt_req) m_mode = M_HALT;
      end else if (m_mode == M_FLUSH) begin
        m_left--;
        if (m_left == 0) m_mode = M_RUN;
      end else if (m_mode == M_HALT) begin
        if (b.resume) m_mode = M_RUN;
      end
      m_halted = (m_mode == M_HALT);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_eval(1'b1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      model_eval(1'b0);
      chk("m_pc_br", 32'(b.pc_br), 32'(x_br));
      chk("m_pc_br_addr", b.pc_br_addr, x_addr);
      chk("m_pc_stall", 32'(b.pc_stall), 32'(x_stall));
      chk("m_flush_if", 32'(b.flush_if), 32'(x_fif));
      chk("m_flush_id", 32'(b.flush_id), 32'(x_fid));
      chk("m_halted", 32'(b.halted), 32'(m_halted));
      chk("m_src", 32'(b.redirect_src), 32'(m_src));
      chk("m_cnt", 32'(b.redirect_cnt), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    b.trap_req = 0; b.trap_addr = 0;
    b.br_req = 0; b.br_addr = 0;
    b.jmp_req = 0; b.jmp_addr = 0;
    b.hazard_stall = 0; b.imem_ready = 1;
    b.halt_req = 0; b.resume = 0;
    repeat (2) tick();
    chk_en = 1;
    mid();
    chk("rst_cnt", 32'(b.redirect_cnt), 0);
    chk("rst_br", 32'(b.pc_br), 0);
    tick();
    rst_n = 1;
    mid();
    chk("rel_br", 32'(b.pc_br), 0);
    chk("rel_stall", 32'(b.pc_stall), 0);
    chk("rel_cnt", 32'(b.redirect_cnt), 0);

    // branch redirect in RUN
    tick();
    b.br_req = 1; b.br_addr = 32'h40;
    mid();
    chk("br_pc_br", 32'(b.pc_br), 1);
    chk("br_addr", b.pc_br_addr, 32'h40);
    chk("br_fif", 32'(b.flush_if), 1);
    chk("br_fid", 32'(b.flush_id), 1);
    tick();
    b.br_req = 0;
    mid();
    chk("br_fl1", 32'(b.flush_if), 1);
    chk("br_src", 32'(b.redirect_src), 2);
    chk("br_cnt", 32'(b.redirect_cnt), 1);
    tick();
    mid();
    chk("br_fl2", 32'(b.flush_if), 1);
    tick();
    mid();
    chk("br_fl_end", 32'(b.flush_if), 0);

    // hazard stall, then jump beating the hazard
    b.hazard_stall = 1;
    mid();
    chk("hz_stall", 32'(b.pc_stall), 1);
    tick();
    b.jmp_req = 1; b.jmp_addr = 32'h24;
    mid();
    chk("hz_jmp_br", 32'(b.pc_br), 1);
    chk("hz_jmp_stall", 32'(b.pc_stall), 0);
    chk("hz_jmp_fid", 32'(b.flush_id), 0);
    tick();
    b.jmp_req = 0; b.hazard_stall = 0;
    repeat (2) tick();

    // jmp held while imem busy, trap overwrites the pending entry
    b.jmp_req = 1; b.jmp_addr = 32'h10; b.imem_ready = 0;
    mid();
    chk("w_stall1", 32'(b.pc_stall), 1);
    tick();
    b.trap_req = 1; b.trap_addr = 32'h80;
    mid();
    chk("w_stall2", 32'(b.pc_stall), 1);
    tick();
    b.trap_req = 0;
    mid();
    chk("w_stall3", 32'(b.pc_stall), 1);
    tick();
    b.imem_ready = 1;
    mid();
    chk("w_issue", 32'(b.pc_br), 1);
    chk("w_addr", b.pc_br_addr, 32'h80);
    tick();
    mid();
    chk("fl_jmp_ign", 32'(b.pc_br), 0);
    chk("w_src", 32'(b.redirect_src), 3);
    tick();
    b.jmp_req = 0; b.br_req = 1; b.br_addr = 32'h200;
    mid();
    chk("fl_br_addr", b.pc_br_addr, 32'h200);
    tick();
    b.br_req = 0;
    tick();
    mid();
    chk("fl_reload", 32'(b.flush_if), 1);
    tick();
    mid();
    chk("fl_reload_end", 32'(b.flush_if), 0);

    // equal-priority overwrite while waiting
    b.jmp_req = 1; b.jmp_addr = 32'h10; b.imem_ready = 0;
    tick();
    b.jmp_addr = 32'h14;
    tick();
    b.jmp_req = 0; b.imem_ready = 1;
    mid();
    chk("ow_addr", b.pc_br_addr, 32'h14);
    tick();
    // trap in FLUSH with imem busy goes through WAIT
    b.trap_req = 1; b.trap_addr = 32'h400; b.imem_ready = 0;
    tick();
    b.trap_req = 0; b.imem_ready = 1;
    mid();
    chk("flw_addr", b.pc_br_addr, 32'h400);
    repeat (3) tick();

    // halt for five cycles, resume pulsed in the fifth
    b.halt_req = 1;
    tick();
    b.halt_req = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) b.resume = 1;
      mid();
      chk("h_halted", 32'(b.halted), 1);
      chk("h_stall", 32'(b.pc_stall), 1);
      tick();
    end
    b.resume = 0;
    mid();
    chk("h_run", 32'(b.halted), 0);
    chk("h_run_stall", 32'(b.pc_stall), 0);
    b.halt_req = 1;
    tick();
    b.halt_req = 0;
    b.br_req = 1; b.br_addr = 32'h700;
    mid();
    chk("h_br_ign", 32'(b.pc_br), 0);
    tick();
    b.br_req = 0;
    b.trap_req = 1; b.trap_addr = 32'h800;
    mid();
    chk("h_trap_addr", b.pc_br_addr, 32'h800);
    chk("h_trap_halted", 32'(b.halted), 1);
    tick();
    b.trap_req = 0;
    mid();
    chk("h_trap_left", 32'(b.halted), 0);
    repeat (3) tick();

    // back-to-back branch re-issues saturate the counter
    b.br_req = 1; b.br_addr = 32'h1000;
    repeat (65540) tick();
    b.br_req = 0;
    mid();
    chk("sat_cnt", 32'(b.redirect_cnt), 32'hFFFF);
    repeat (3) tick();
    b.br_req = 1;
    tick();
    b.br_req = 0;
    mid();
    chk("sat_hold", 32'(b.redirect_cnt), 32'hFFFF);
    repeat (3) tick();

    // async reset while a jump waits on imem
    b.jmp_req = 1; b.jmp_addr = 32'h50; b.imem_ready = 0;
    tick();
    #2;
    rst_n = 0;
    b.jmp_req = 0; b.imem_ready = 1;
    b.br_req = 1; b.br_addr = 32'h60;
    mid();
    chk("ar_cnt", 32'(b.redirect_cnt), 0);
    chk("ar_br", 32'(b.pc_br), 0);
    chk("ar_fif", 32'(b.flush_if), 0);
    tick();
    b.br_req = 0;
    rst_n = 1;
    mid();
    chk("ar_rel_br", 32'(b.pc_br), 0);
    chk("ar_rel_src", 32'(b.redirect_src), 0);
    chk("ar_rel_stall", 32'(b.pc_stall), 0);
    repeat (3) tick();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequences the fetch-stage program counter register. Arbitrates redirect requests (trap, EX-stage branch, ID-stage jump), stall sources (load-use hazard, instruction-memory wait) and halt/resume. Drives the PC register's branch, branch-address and stall inputs plus the IF/ID flush lines. Holds a redirect that cannot issue while instruction memory is busy, and enforces a wrong-path flush window after every redirect.

## Interface
- FLUSH_CYCLES, 2, cycles flush_if stays high after a redirect issues (legal range 1..15)
- ADDR_W, 32, PC width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- trap_req / trap_addr  in  1 / ADDR_W  trap redirect, priority 3 (highest)
- br_req / br_addr  in  1 / ADDR_W  EX branch redirect, priority 2
- jmp_req / jmp_addr  in  1 / ADDR_W  ID jump redirect, priority 1
- hazard_stall  in  1  load-use stall request
- imem_ready  in  1  instruction memory accepts a fetch this cycle
- halt_req  in  1  level; request halt
- resume  in  1  pulse; leave HALT
- pc_br  out  1  load pc_br_addr into PC at this edge
- pc_br_addr  out  ADDR_W  redirect target
- pc_stall  out  1  hold PC
- flush_if  out  1  squash IF-stage instruction
- flush_id  out  1  squash ID-stage instruction
- halted  out  1  in HALT state
- redirect_src  out  2  last issued source: 0 none, 1 jmp, 2 br, 3 trap
- redirect_cnt  out  16  issued redirects, saturating at 0xFFFF

## Operation
- Winner: the highest-priority active request among trap, br, jmp. In FLUSH, jmp_req is ignored (wrong path). In HALT, only trap_req is considered.
- Issue: pc_br=1 and pc_br_addr=winner or pending address. flush_if=1. flush_id=1 when the source is br or trap. redirect_src is updated. redirect_cnt increments by 1 and holds at 0xFFFF. The flush counter loads FLUSH_CYCLES-1. Next state is FLUSH.
- States: RUN, WAIT, FLUSH, HALT.
- RUN:
  - Winner and imem_ready: issue.
  - Winner and !imem_ready: latch pending_addr and pending_src, go to WAIT.
  - Otherwise, halt_req: go to HALT.
  - Otherwise: pc_stall = hazard_stall | !imem_ready.
- WAIT:
  - pc_stall=1.
  - A new request of equal or higher priority than the pending one overwrites the pending entry.
  - imem_ready: issue from the pending entry, or from an overwriting request in the same cycle.
- FLUSH:
  - flush_if=1.
  - pc_stall = hazard_stall | !imem_ready.
  - trap or br: re-issue with counter reload if imem_ready, otherwise go to WAIT.
  - Counter == 0 with no new issue: go to RUN. Otherwise the counter decrements.
- HALT:
  - pc_stall=1, halted=1.
  - trap_req issues and leaves HALT.
  - resume: go to RUN next cycle.
- Simultaneous events:
  - A redirect beats halt_req. halt_req is level and is re-evaluated in RUN.
  - pc_br=1 implies pc_stall=0, regardless of hazard_stall.
- Reset (async, any state, including mid-WAIT):
  - State = RUN, pending entry cleared, flush counter 0.
  - pc_br=0, pc_br_addr=0, flush_if=0, flush_id=0, halted=0, redirect_src=0, redirect_cnt=0.
  - pc_stall follows RUN decode: hazard_stall | !imem_ready.

## Timing
- pc_br, pc_br_addr, pc_stall, flush_if, flush_id are Mealy outputs, combinational from state and inputs.
  - The PC register loads the target at the same rising edge: 0-cycle redirect latency when imem_ready is high.
  - From WAIT, the redirect issues in the first cycle imem_ready is high.
- halted, redirect_src, redirect_cnt are registered; they update one edge after the causing event.
- FLUSH lasts exactly FLUSH_CYCLES cycles after the issue cycle, absent re-issue. flush_if is high in the issue cycle plus those cycles.
- The first PC increment after resume happens at the edge following the RUN cycle, given no stall.

## Test plan
- Reset, then release rst_n with imem_ready=1 and no requests -> pc_br=0, pc_stall=0, redirect_cnt=0.
- br_req with br_addr=0x40 in RUN, imem_ready=1 -> same cycle: pc_br=1, pc_br_addr=0x40, flush_if=1, flush_id=1. Then flush_if stays high 2 more cycles. Then redirect_src=2, redirect_cnt=1.
- jmp_req with addr 0x10 and imem_ready=0 for 3 cycles; trap_req with addr 0x80 in cycle 2; imem_ready high in cycle 4 -> pc_stall=1 for cycles 1–3. Cycle 4: pc_br_addr=0x80, redirect_src=3.
- jmp_req during FLUSH -> ignored, pc_br=0. br_req during FLUSH -> issues, flush counter reloads.
- halt_req with resume pulsed after 5 cycles -> halted=1 and pc_stall=1 for those 5 cycles, RUN afterwards. trap_req during HALT -> issues, halted=0 next edge.
- Force 0xFFFF redirects, then issue one more -> redirect_cnt stays 0xFFFF. Drop rst_n mid-WAIT -> pending discarded, pc_br=0 after release.
